// File: rtl/modexp_wb_sched_pkg.sv
// Shared definitions for the modexp Wishbone scheduler: accelerator register map,
// control/status bit positions and the sequencing FSM encoding.
package modexp_wb_sched_pkg;

    localparam logic [3:0] ADDR_BASE   = 4'd0;
    localparam logic [3:0] ADDR_EXP    = 4'd1;
    localparam logic [3:0] ADDR_MOD    = 4'd2;
    localparam logic [3:0] ADDR_CTRL   = 4'd3;
    localparam logic [3:0] ADDR_RESULT = 4'd4;
    localparam logic [3:0] ADDR_STATUS = 4'd5;

    localparam int CTRL_START_BIT   = 0;
    localparam int STATUS_READY_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_BASE  = 4'd1,
        ST_WR_EXP   = 4'd2,
        ST_WR_MOD   = 4'd3,
        ST_WR_START = 4'd4,
        ST_POLL     = 4'd5,
        ST_GAP      = 4'd6,
        ST_RD_RES   = 4'd7,
        ST_RESP     = 4'd8
    } state_t;

    function automatic logic is_bus_state(input state_t s);
        return s inside {ST_WR_BASE, ST_WR_EXP, ST_WR_MOD, ST_WR_START, ST_POLL, ST_RD_RES};
    endfunction

    function automatic logic [3:0] state_addr(input state_t s);
        logic [3:0] a;
        a = 4'd0;
        case (s)
            ST_WR_BASE:  a = ADDR_BASE;
            ST_WR_EXP:   a = ADDR_EXP;
            ST_WR_MOD:   a = ADDR_MOD;
            ST_WR_START: a = ADDR_CTRL;
            ST_POLL:     a = ADDR_STATUS;
            ST_RD_RES:   a = ADDR_RESULT;
            default:     a = 4'd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/modexp_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_idx
);

    always_comb begin
        o_valid = |i_req;
        case (i_req)
            2'b11:   o_idx = ~i_last;
            2'b10:   o_idx = 1'b1;
            default: o_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/modexp_wb_sched.sv
// Serves modular-exponentiation jobs from two requesters on a Wishbone-attached
// accelerator: write operands, start, poll status with gaps, read result, respond.
module modexp_wb_sched
    import modexp_wb_sched_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int MAX_POLLS = 1024,
    parameter int POLL_GAP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_base,
    input  logic [2*WIDTH-1:0] req_exp,
    input  logic [2*WIDTH-1:0] req_mod,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [3:0]         wb_addr,
    output logic [WIDTH-1:0]   wb_dat_o,
    input  logic [WIDTH-1:0]   wb_dat_i,
    output logic               wb_we,
    output logic               wb_stb,
    output logic               wb_cyc,
    input  logic               wb_ack,
    output logic               busy,
    output logic               grant_id
);

    localparam int PW = $clog2(MAX_POLLS + 2);
    localparam int GW = $clog2(POLL_GAP + 2);

    state_t           r_state;
    state_t           w_state_next;
    // r_phase: 0 = idle cycle before a bus access, 1 = strobe asserted awaiting ack
    logic             r_phase;
    logic             w_phase_next;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic             r_grant_id;
    logic             r_last_grant;
    logic [PW-1:0]    r_poll_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic             w_gnt_valid;
    logic             w_gnt_idx;
    logic             w_accept;
    logic             w_bus_ack;
    logic             w_poll_ack;
    logic             w_res_ack;
    logic             w_status_ready;
    logic             w_timeout;
    logic             w_mod_zero;
    logic [PW-1:0]    w_poll_cnt_inc;

    rr_arb2 u_arb (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    assign w_accept       = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_bus_ack      = r_phase && wb_ack;
    assign w_poll_ack     = (r_state == ST_POLL) && w_bus_ack;
    assign w_res_ack      = (r_state == ST_RD_RES) && w_bus_ack;
    assign w_status_ready = wb_dat_i[STATUS_READY_BIT];
    assign w_poll_cnt_inc = r_poll_cnt + PW'(1);
    assign w_timeout      = w_poll_ack && !w_status_ready && (w_poll_cnt_inc == PW'(MAX_POLLS));
    assign w_mod_zero     = (r_state == ST_WR_BASE) && (r_mod == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_WR_BASE;
                    w_phase_next = 1'b0;
                end
            end
            ST_WR_BASE, ST_WR_EXP, ST_WR_MOD, ST_WR_START, ST_POLL, ST_RD_RES: begin
                if (w_mod_zero) begin
                    w_state_next = ST_RESP;
                    w_phase_next = 1'b0;
                end else if (!r_phase) begin
                    w_phase_next = 1'b1;
                end else if (wb_ack) begin
                    w_phase_next = 1'b0;
                    case (r_state)
                        ST_WR_BASE:  w_state_next = ST_WR_EXP;
                        ST_WR_EXP:   w_state_next = ST_WR_MOD;
                        ST_WR_MOD:   w_state_next = ST_WR_START;
                        ST_WR_START: w_state_next = ST_POLL;
                        ST_POLL: begin
                            if (w_status_ready)      w_state_next = ST_RD_RES;
                            else if (w_timeout)      w_state_next = ST_RESP;
                            else if (POLL_GAP == 0)  w_state_next = ST_POLL;
                            else                     w_state_next = ST_GAP;
                        end
                        default:     w_state_next = ST_RESP;
                    endcase
                end
            end
            ST_GAP: begin
                // The gap itself is the idle spacing, so the next poll strobes immediately.
                if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
                    w_state_next = ST_POLL;
                    w_phase_next = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready[r_grant_id]) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = 4'd0;
        wb_dat_o = '0;
        if (r_phase && is_bus_state(r_state)) begin
            wb_cyc  = 1'b1;
            wb_stb  = 1'b1;
            wb_addr = state_addr(r_state);
            case (r_state)
                ST_WR_BASE: begin
                    wb_we    = 1'b1;
                    wb_dat_o = r_base;
                end
                ST_WR_EXP: begin
                    wb_we    = 1'b1;
                    wb_dat_o = r_exp;
                end
                ST_WR_MOD: begin
                    wb_we    = 1'b1;
                    wb_dat_o = r_mod;
                end
                ST_WR_START: begin
                    wb_we                    = 1'b1;
                    wb_dat_o[CTRL_START_BIT] = 1'b1;
                end
                default: wb_we = 1'b0;
            endcase
        end
        busy      = (r_state != ST_IDLE);
        req_ready = w_accept ? {w_gnt_idx, ~w_gnt_idx} : 2'b00;
        rsp_valid = (r_state == ST_RESP) ? {r_grant_id, ~r_grant_id} : 2'b00;
        rsp_data  = r_rsp_data;
        rsp_err   = r_rsp_err;
        grant_id  = r_grant_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base       <= '0;
            r_exp        <= '0;
            r_mod        <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_poll_cnt   <= '0;
            r_gap_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_base       <= w_gnt_idx ? req_base[2*WIDTH-1:WIDTH] : req_base[WIDTH-1:0];
                r_exp        <= w_gnt_idx ? req_exp[2*WIDTH-1:WIDTH]  : req_exp[WIDTH-1:0];
                r_mod        <= w_gnt_idx ? req_mod[2*WIDTH-1:WIDTH]  : req_mod[WIDTH-1:0];
                r_grant_id   <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
                r_poll_cnt   <= '0;
            end else if (w_poll_ack) begin
                r_poll_cnt <= w_poll_cnt_inc;
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
            if (w_mod_zero || w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end else if (w_res_ack) begin
                r_rsp_data <= wb_dat_i;
                r_rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modexp_wb_sched.sv
// Bench for modexp_wb_sched: Wishbone accelerator model with random wait states,
// scoreboard of expected responses from modular-power arithmetic and round-robin order.
module tb_modexp_wb_sched;

    localparam int W  = 32;
    localparam int MP = 8;
    localparam int PG = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_base = '0;
    logic [2*W-1:0] req_exp = '0;
    logic [2*W-1:0] req_mod = '0;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready = 2'b00;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [3:0]     wb_addr;
    logic [W-1:0]   wb_dat_o;
    logic [W-1:0]   wb_dat_i;
    logic           wb_we, wb_stb, wb_cyc, wb_ack, busy, grant_id;

    always #5 clk = ~clk;

    modexp_wb_sched #(.WIDTH(W), .MAX_POLLS(MP), .POLL_GAP(PG)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_exp(req_exp), .req_mod(req_mod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wb_addr(wb_addr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .busy(busy), .grant_id(grant_id)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        longint unsigned r, x, mm;
        if (m == '0) return '0;
        mm = 64'(m);
        r  = 1 % mm;
        x  = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    // ---------------- accelerator model ----------------
    int           cfg_ready_after = 1;
    int           cfg_wait_max = 0;
    int           slave_wait = 0;
    int           polls_seen = 0;
    int           proto_err = 0;
    int           cyc_n = 0;
    int           cyc_high = 0;
    int           cur_start = 0;
    int           start_v;
    logic         prev_stb = 1'b0;
    logic         prev_acked = 1'b0;
    logic [3:0]   cur_addr = 4'd0;
    logic         cur_we = 1'b0;
    logic [W-1:0] cur_dat = '0;
    logic [W-1:0] acc_reg [0:3];
    logic [W-1:0] acc_result = '0;
    logic [3:0]   log_addr [$];
    logic         log_we [$];
    logic [W-1:0] log_dat [$];
    int           log_start [$];
    int           log_end [$];

    assign wb_ack  = wb_stb & wb_cyc & (slave_wait == 0);
    assign start_v = (wb_stb && !prev_stb) ? cyc_n : cur_start;

    always_comb begin
        wb_dat_i = '0;
        if (wb_addr == 4'd4) wb_dat_i = acc_result;
        else if (wb_addr == 4'd5)
            wb_dat_i = {{(W-1){1'b0}}, (cfg_ready_after != 0) && (polls_seen + 1 >= cfg_ready_after)};
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rst) begin
            slave_wait <= 0;
            prev_stb   <= 1'b0;
            prev_acked <= 1'b0;
        end else begin
            prev_stb   <= wb_stb;
            prev_acked <= wb_stb & wb_ack;
            if (wb_cyc) cyc_high <= cyc_high + 1;
            proto_err <= proto_err + int'(wb_stb !== wb_cyc) + int'(wb_stb && prev_acked)
                       + int'(wb_stb && prev_stb && !prev_acked &&
                              ((wb_addr !== cur_addr) || (wb_we !== cur_we) || (wb_dat_o !== cur_dat)));
            if (wb_stb && !prev_stb) begin
                cur_start <= cyc_n;
                cur_addr  <= wb_addr;
                cur_we    <= wb_we;
                cur_dat   <= wb_dat_o;
            end
            if (wb_ack) begin
                log_addr.push_back(wb_addr);
                log_we.push_back(wb_we);
                log_dat.push_back(wb_we ? wb_dat_o : wb_dat_i);
                log_start.push_back(start_v);
                log_end.push_back(cyc_n);
                if (wb_we && wb_addr < 4'd4) acc_reg[wb_addr[1:0]] <= wb_dat_o;
                if (wb_we && wb_addr == 4'd3 && wb_dat_o[0]) begin
                    acc_result <= modpow(acc_reg[0], acc_reg[1], acc_reg[2]);
                    polls_seen <= 0;
                end
                if (!wb_we && wb_addr == 4'd5) polls_seen <= polls_seen + 1;
                slave_wait <= int'($urandom_range(0, cfg_wait_max));
            end else if (wb_stb && wb_cyc && slave_wait != 0) begin
                slave_wait <= slave_wait - 1;
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [W+1:0] exp_q [$];   // {requester, err, data}
    logic         model_last = 1'b1;
    int           accept_cyc = 0;
    int           last_lat = 0;

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [W+1:0] expect_rsp(input logic idx, input logic [W-1:0] b,
                                                 input logic [W-1:0] e, input logic [W-1:0] m);
        if (m == '0 || cfg_ready_after == 0 || cfg_ready_after > MP) return {idx, 1'b1, {W{1'b0}}};
        return {idx, 1'b0, modpow(b, e, m)};
    endfunction

    task automatic drive(input logic idx, input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        if (idx) begin
            req_base[2*W-1:W] = b; req_exp[2*W-1:W] = e; req_mod[2*W-1:W] = m;
        end else begin
            req_base[W-1:0] = b; req_exp[W-1:0] = e; req_mod[W-1:0] = m;
        end
        req_valid[idx] = 1'b1;
    endtask

    task automatic submit(input logic idx, input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        drive(idx, b, e, m);
        exp_q.push_back(expect_rsp(idx, b, e, m));
        model_last = idx;
    endtask

    task automatic submit_pair(input logic [W-1:0] b0, input logic [W-1:0] e0, input logic [W-1:0] m0,
                               input logic [W-1:0] b1, input logic [W-1:0] e1, input logic [W-1:0] m1);
        logic first;
        first = ~model_last;
        drive(1'b0, b0, e0, m0);
        drive(1'b1, b1, e1, m1);
        if (first) begin
            exp_q.push_back(expect_rsp(1'b1, b1, e1, m1));
            exp_q.push_back(expect_rsp(1'b0, b0, e0, m0));
        end else begin
            exp_q.push_back(expect_rsp(1'b0, b0, e0, m0));
            exp_q.push_back(expect_rsp(1'b1, b1, e1, m1));
        end
        model_last = ~first;
    endtask

    // Called at a negedge where req_valid & req_ready is nonzero.
    task automatic do_accept();
        logic [1:0] acc;
        acc = req_valid & req_ready;
        check("grant_idx", acc, oh(exp_q[0][W+1]));
        @(posedge clk);
        #1;
        req_valid  = req_valid & ~acc;
        accept_cyc = cyc_n;
        check("grant_id", grant_id, exp_q[0][W+1]);
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_accept();
        int budget;
        bit got;
        budget = 50;
        got = 1'b0;
        while (budget > 0 && !got) begin
            @(negedge clk);
            budget--;
            if ((req_valid & req_ready) != 2'b00) begin
                do_accept();
                got = 1'b1;
            end
        end
        check("accept_seen", got, 1'b1);
    endtask

    task automatic drain(input int hold);
        int budget;
        logic [W+1:0] e;
        budget = 3000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if ((req_valid & req_ready) != 2'b00) begin
                do_accept();
            end else if (rsp_valid != 2'b00) begin
                e = exp_q.pop_front();
                last_lat = cyc_n - accept_cyc;
                check("rsp_valid", rsp_valid, oh(e[W+1]));
                check("rsp_data", rsp_data, e[W-1:0]);
                check("rsp_err", rsp_err, e[W]);
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("hold_valid", rsp_valid, oh(e[W+1]));
                    check("hold_data", rsp_data, e[W-1:0]);
                    check("hold_err", rsp_err, e[W]);
                    check("hold_req_ready", req_ready, 2'b00);
                end
                rsp_ready = rsp_valid;
                @(posedge clk);
                #1;
                rsp_ready = 2'b00;
            end
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, cnt, cyc_before, npolls;
        int exp_addr [8];
        logic [W-1:0] exp_wdat [4];
        logic [W-1:0] rb, re, rm, rb2, re2, rm2;
        exp_addr = '{0, 1, 2, 3, 5, 5, 5, 4};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_wb_stb_cyc", {wb_stb, wb_cyc, wb_we}, 3'b000);
        check("rst_wb_addr_dat", {wb_addr, wb_dat_o}, '0);
        check("rst_rsp_data_err", {rsp_data, rsp_err}, '0);
        rst = 1'b0;
        @(negedge clk);

        // single job from requester 0, ready on the third poll
        cfg_ready_after = 3;
        cfg_wait_max = 0;
        mark = log_addr.size();
        submit(1'b0, 32'd4, 32'd13, 32'd497);
        drain(0);
        check("t41_nacc", log_addr.size() - mark, 8);
        for (int i = 0; i < 8; i++) check("t41_addr", log_addr[mark + i], 4'(exp_addr[i]));
        exp_wdat = '{32'd4, 32'd13, 32'd497, 32'd1};
        for (int i = 0; i < 4; i++) check("t41_wdat", log_dat[mark + i], exp_wdat[i]);
        check("t41_result_read", log_dat[mark + 7], modpow(32'd4, 32'd13, 32'd497));

        // minimum latency: zero wait, ready on first poll
        cfg_ready_after = 1;
        submit(1'b1, $urandom, $urandom, $urandom | 32'd1);
        drain(0);
        check("min_latency", last_lat, 2 * (4 + 1 + 1));

        // simultaneous pair
        submit_pair(32'd5, 32'd117, 32'd19, 32'd7, 32'd256, 32'd13);
        drain(0);

        // zero modulus: no bus activity, fast error response
        cyc_before = cyc_high;
        submit(1'b0, 32'd9, 32'd3, 32'd0);
        drain(0);
        check("mod0_no_cyc", cyc_high - cyc_before, 0);
        check("mod0_latency_le3", last_lat <= 3, 1'b1);

        // second simultaneous pair (requester 0 served last)
        rb = $urandom; re = $urandom; rm = $urandom | 32'd1;
        rb2 = $urandom; re2 = $urandom; rm2 = $urandom | 32'd1;
        submit_pair(rb, re, rm, rb2, re2, rm2);
        drain(0);

        // random jobs with wait states
        cfg_wait_max = 3;
        for (int k = 0; k < 6; k++) begin
            cfg_ready_after = int'($urandom_range(1, 3));
            case ($urandom_range(0, 2))
                0: submit(1'b0, $urandom, $urandom, $urandom | 32'd1);
                1: submit(1'b1, $urandom, $urandom, $urandom | 32'd1);
                default: submit_pair($urandom, $urandom, $urandom | 32'd1,
                                     $urandom, $urandom, $urandom | 32'd1);
            endcase
            drain(0);
        end

        // timeout: status never ready
        cfg_ready_after = 0;
        cfg_wait_max = 0;
        mark = log_addr.size();
        submit(1'b1, $urandom, $urandom, $urandom | 32'd1);
        drain(0);
        npolls = 0;
        cnt = 0;
        for (int i = mark; i < log_addr.size(); i++) begin
            if (log_addr[i] == 4'd5) npolls++;
            if (log_addr[i] == 4'd4) cnt++;
        end
        check("timeout_polls", npolls, MP);
        check("timeout_no_result_read", cnt, 0);
        for (int i = mark + 5; i < log_addr.size(); i++)
            check("poll_gap", log_start[i] - log_end[i - 1] - 1, PG);

        // response held while rsp_ready low; other requester waits
        cfg_ready_after = 2;
        cfg_wait_max = 1;
        submit(1'b0, $urandom, $urandom, $urandom | 32'd1);
        wait_accept();
        submit(1'b1, $urandom, $urandom, $urandom | 32'd1);
        drain(10);

        // reset during the exponent write
        cfg_ready_after = 1;
        cfg_wait_max = 0;
        submit(1'b0, $urandom, $urandom, $urandom | 32'd1);
        wait_accept();
        cnt = 0;
        while (cnt < 20 && !(wb_stb && wb_addr == 4'd1)) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_mid_reached_wr_exp", {wb_stb, wb_addr}, 5'h11);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_stb_cyc", {wb_stb, wb_cyc}, 2'b00);
        check("rst_mid_busy", busy, 1'b0);
        exp_q.delete();
        model_last = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) cnt++;
        end
        check("rst_mid_no_rsp", cnt, 0);

        // after reset requester 0 wins a simultaneous pair again
        submit_pair($urandom, $urandom, $urandom | 32'd1, $urandom, $urandom, $urandom | 32'd1);
        drain(0);

        check("bus_protocol_errors", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
